feature_map_streamer_layer6: RTL and testbench

FEATURE_MAP_STREAMER_LAYER6 -- requirements
Module: feature_map_streamer_layer6

---
 rtl/feature_map_streamer_layer6_pkg.sv | 5 +
 rtl/feature_map_streamer_layer6_stream_fifo.sv | 42 ++++
 rtl/feature_map_streamer_layer6.sv | 104 ++++++++++
 tb/tb_feature_map_streamer_layer6.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/feature_map_streamer_layer6_pkg.sv
// feature_map_streamer_layer6_pkg: shared state encoding and channel count for the layer-6 streamer.
package feature_map_streamer_layer6_pkg;
  localparam int CHANNELS = 64;
  typedef enum logic [1:0] {IDLE, STREAM, GAP, DONE} state_t;
endpackage

// File: rtl/feature_map_streamer_layer6_stream_fifo.sv
// stream_fifo: power-of-2 pixel FIFO with registered read data and registered occupancy count.
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNTW-1:0] r_count;
  logic w_push, w_pop;
  assign o_empty = r_count == '0;
  assign o_full = r_count == CNTW'(DEPTH);
  assign w_push = i_wr_en && !o_full;
  assign w_pop = i_rd_en && !o_empty;
  assign o_rd_data = r_rd_data;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
      r_rd_data <= '0;
    end else begin
      r_wr_ptr <= w_push ? r_wr_ptr + AW'(1) : r_wr_ptr;
      r_rd_ptr <= w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
      r_count <= r_count + CNTW'(w_push) - CNTW'(w_pop);
      r_rd_data <= w_pop ? r_mem[r_rd_ptr] : r_rd_data;
    end
  end
endmodule

// File: rtl/feature_map_streamer_layer6.sv
// feature_map_streamer_layer6: FIFO-buffered frame streamer feeding 64-channel pixels into layer 6.
// Define STREAMER_ROW_GAP_EN to insert ROW_GAP idle cycles after every row but the last.
module feature_map_streamer_layer6
  import feature_map_streamer_layer6_pkg::*;
#(
  parameter int DATA_WIDHT = 32,
  parameter int IMG_WIDHT  = 44,
  parameter int IMG_HEIGHT = 44,
  parameter int FIFO_DEPTH = 8
`ifdef STREAMER_ROW_GAP_EN
  ,
  parameter int ROW_GAP    = 2
`endif
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           Start,
  input  logic [DATA_WIDHT*CHANNELS-1:0] S_Data,
  input  logic                           S_Valid,
  output logic                           S_Ready,
  output logic [DATA_WIDHT*CHANNELS-1:0] Data_Out,
  output logic                           Valid_Out,
  output logic                           Sof,
  output logic                           Eol,
  output logic                           Eof,
  output logic                           Busy,
  output logic                           Done
);
  localparam int CW = IMG_WIDHT > 1 ? $clog2(IMG_WIDHT) : 1;
  localparam int RW = IMG_HEIGHT > 1 ? $clog2(IMG_HEIGHT) : 1;
  state_t r_state, w_next;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic w_empty, w_full, w_pop, w_eol, w_last;
  logic r_valid, r_sof, r_eol, r_eof, r_done;
  assign w_eol = r_col == CW'(IMG_WIDHT - 1);
  assign w_last = w_eol && r_row == RW'(IMG_HEIGHT - 1);
  assign w_pop = r_state == STREAM && !w_empty;
  // Ready is masked by reset so upstream never sees a free slot while the FIFO is held cleared.
  assign S_Ready = rst && !w_full;
  assign Valid_Out = r_valid;
  assign Sof = r_sof;
  assign Eol = r_eol;
  assign Eof = r_eof;
  assign Busy = r_state != IDLE;
  assign Done = r_done;
  stream_fifo #(.WIDTH(DATA_WIDHT*CHANNELS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .i_wr_en  (S_Valid),
    .i_wr_data(S_Data),
    .i_rd_en  (w_pop),
    .o_rd_data(Data_Out),
    .o_empty  (w_empty),
    .o_full   (w_full)
  );
`ifdef STREAMER_ROW_GAP_EN
  localparam int GW = ROW_GAP > 1 ? $clog2(ROW_GAP) : 1;
  logic [GW-1:0] r_gap;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_gap <= '0;
    else r_gap <= r_state == GAP ? r_gap + GW'(1) : '0;
`endif
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   w_next = Start ? STREAM : IDLE;
      STREAM: if (w_pop && w_last) w_next = DONE;
`ifdef STREAMER_ROW_GAP_EN
              else if (w_pop && w_eol) w_next = GAP;
      GAP:    w_next = r_gap == GW'(ROW_GAP - 1) ? STREAM : GAP;
`else
      GAP:    w_next = STREAM;
`endif
      DONE:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_col <= '0;
      r_row <= '0;
      r_valid <= 1'b0;
      r_sof <= 1'b0;
      r_eol <= 1'b0;
      r_eof <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= w_pop;
      r_sof <= w_pop && r_col == '0 && r_row == '0;
      r_eol <= w_pop && w_eol;
      r_eof <= w_pop && w_last;
      r_done <= r_state == DONE;
      if (r_state == IDLE && Start) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_pop) begin
        r_col <= w_eol ? '0 : r_col + CW'(1);
        r_row <= w_last ? '0 : w_eol ? r_row + RW'(1) : r_row;
      end
    end
  end
endmodule

// File: tb/tb_feature_map_streamer_layer6.sv
// tb_feature_map_streamer_layer6: table-driven plus scoreboard bench for the layer-6 streamer (4x3 frame, 4-deep FIFO).
module tb_feature_map_streamer_layer6;
  localparam int DWD = 4;
  localparam int DW = DWD * 64;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;
  localparam int DEPTH = 4;
`ifdef STREAMER_ROW_GAP_EN
  localparam int G = 2;
`else
  localparam int G = 0;
`endif
  localparam int NV = 15 + 2 * G;

  logic clk, rst, Start, S_Valid, S_Ready, Valid_Out, Sof, Eol, Eof, Busy, Done;
  logic [DW-1:0] S_Data, Data_Out;

  feature_map_streamer_layer6 #(
    .DATA_WIDHT(DWD), .IMG_WIDHT(W), .IMG_HEIGHT(H), .FIFO_DEPTH(DEPTH)
`ifdef STREAMER_ROW_GAP_EN
    , .ROW_GAP(G)
`endif
  ) dut (
    .clk(clk), .rst(rst), .Start(Start), .S_Data(S_Data), .S_Valid(S_Valid), .S_Ready(S_Ready),
    .Data_Out(Data_Out), .Valid_Out(Valid_Out), .Sof(Sof), .Eol(Eol), .Eof(Eof), .Busy(Busy), .Done(Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask
  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic chk_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: every word the upstream handshake accepts, in order.
  logic [DW-1:0] q[$];
  int feed_left = 0;
  int feed_mode = 0;
  int feed_idx = 0;
  int ph = 0;

  initial begin
    S_Valid = 1'b0;
    S_Data = '0;
    forever begin
      @(negedge clk);
      ph++;
      S_Valid = feed_left > 0 && (feed_mode == 2 ? $urandom_range(1) == 1 : feed_mode == 1 ? ph % 3 == 0 : 1'b1);
      if (feed_mode == 2) for (int i = 0; i < 8; i++) S_Data[i*32 +: 32] = $urandom();
      else S_Data = DW'(feed_idx);
      #1;
      if (S_Valid && S_Ready) begin
        q.push_back(S_Data);
        feed_idx++;
        feed_left--;
      end
    end
  end

  // Output monitor: compares every beat against the model queue and frame position rules.
  int cyc = 0;
  int fb = 0;
  int eof_cyc = -10;
  int done_cnt = 0;
  int total_beats = 0;
  int beat_cyc[N];
  logic [DW-1:0] beat_dat[N];
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      if (Valid_Out) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected: got data %h, expected no beat", Data_Out);
        end else chk_d($sformatf("beat%0d_data", fb), Data_Out, q.pop_front());
        chk_b($sformatf("beat%0d_sof", fb), Sof, fb == 0);
        chk_b($sformatf("beat%0d_eol", fb), Eol, fb % W == W - 1);
        chk_b($sformatf("beat%0d_eof", fb), Eof, fb == N - 1);
        beat_cyc[fb] = cyc;
        beat_dat[fb] = Data_Out;
        total_beats++;
        if (fb == N - 1) begin
          eof_cyc = cyc;
          fb = 0;
        end else fb++;
      end
      if (Done) begin
        chk_i("done_timing", cyc, eof_cyc + 1);
        done_cnt++;
      end
    end
  end

  typedef struct packed {
    logic start;
    logic valid;
    logic [DW-1:0] data;
    logic sof, eol, eof, done, busy, chk_ready, ready;
  } vec_t;
  vec_t tbl[NV];

  function automatic int beat_c(input int k);
    return 1 + k + G * (k / W);
  endfunction

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  task automatic wait_done(input int n0, input int budget);
    int k = 0;
    while (done_cnt == n0 && k < budget) begin
      step();
      k++;
    end
    chk_b("done_seen", done_cnt != n0, 1'b1);
  endtask

  task automatic wait_fb(input int target);
    int k = 0;
    while (fb < target && k < 200) begin
      step();
      k++;
    end
    chk_b("beat_reached", fb >= target, 1'b1);
  endtask

  task automatic check_gaps(input bit underrun);
    for (int k = 0; k < N - 1; k++)
      chk_i($sformatf("gap%0d", k), beat_cyc[k+1] - beat_cyc[k], underrun ? 3 : 1 + (k % W == W - 1 ? G : 0));
  endtask

  task automatic check_data(input int base);
    for (int k = 0; k < N; k++) chk_d($sformatf("frame_data%0d", k), beat_dat[k], DW'(base + k));
  endtask

  task automatic feed(input int mode, input int base, input int n);
    feed_mode = mode;
    feed_idx = base;
    feed_left = n;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  int d0, b0;
  initial begin
    for (int c = 0; c < NV; c++) begin
      tbl[c] = '0;
      tbl[c].start = c == 0;
      for (int k = 0; k < N; k++)
        if (beat_c(k) == c) begin
          tbl[c].valid = 1'b1;
          tbl[c].data = DW'(k);
          tbl[c].sof = k == 0;
          tbl[c].eol = k % W == W - 1;
          tbl[c].eof = k == N - 1;
        end
      tbl[c].done = c == beat_c(N - 1) + 1;
      tbl[c].busy = c <= beat_c(N - 1);
      tbl[c].chk_ready = c <= 1;
      tbl[c].ready = c == 1;
    end
    rst = 1'b0;
    Start = 1'b0;
    #1;
    chk_d("rst_data", Data_Out, '0);
    chk_b("rst_valid", Valid_Out, 1'b0);
    chk_b("rst_ready", S_Ready, 1'b0);
    chk_b("rst_busy", Busy, 1'b0);
    chk_b("rst_done", Done, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    chk_b("idle_ready", S_Ready, 1'b1);

    // Basic frame with prefetch while idle: FIFO fills to 4 then backpressures.
    feed(0, 0, N);
    repeat (8) step();
    chk_i("prefill_count", q.size(), DEPTH);
    chk_b("prefill_ready_low", S_Ready, 1'b0);
    chk_b("prefill_no_valid", Valid_Out, 1'b0);
    for (int c = 0; c < NV; c++) begin
      Start = tbl[c].start;
      step();
      chk_b($sformatf("t%0d_valid", c), Valid_Out, tbl[c].valid);
      if (tbl[c].valid) begin
        chk_d($sformatf("t%0d_data", c), Data_Out, tbl[c].data);
        chk_b($sformatf("t%0d_sof", c), Sof, tbl[c].sof);
        chk_b($sformatf("t%0d_eol", c), Eol, tbl[c].eol);
        chk_b($sformatf("t%0d_eof", c), Eof, tbl[c].eof);
      end
      chk_b($sformatf("t%0d_done", c), Done, tbl[c].done);
      chk_b($sformatf("t%0d_busy", c), Busy, tbl[c].busy);
      if (tbl[c].chk_ready) chk_b($sformatf("t%0d_ready", c), S_Ready, tbl[c].ready);
    end
    check_gaps(1'b0);
    chk_i("basic_done_cnt", done_cnt, 1);

    // Underrun: one word every 3 cycles, fed only from the Start cycle on.
    Start = 1'b1;
    feed(1, 100, N);
    step();
    Start = 1'b0;
    wait_done(1, 300);
    check_gaps(1'b1);
    check_data(100);

    // Start while busy is ignored.
    d0 = done_cnt;
    b0 = total_beats;
    feed(0, 200, N);
    repeat (6) step();
    pulse_start();
    wait_fb(6);
    pulse_start();
    wait_done(d0, 200);
    repeat (6) step();
    chk_i("busy_start_beats", total_beats - b0, N);
    chk_i("busy_start_dones", done_cnt - d0, 1);
    chk_b("busy_start_idle", Busy, 1'b0);
    check_gaps(1'b0);
    check_data(200);

    // Reset mid-frame after beat 5.
    feed(0, 300, N);
    repeat (6) step();
    pulse_start();
    wait_fb(6);
    feed_left = 0;
    rst = 1'b0;
    #1;
    chk_d("midrst_data", Data_Out, '0);
    chk_b("midrst_valid", Valid_Out, 1'b0);
    chk_b("midrst_sof", Sof, 1'b0);
    chk_b("midrst_eol", Eol, 1'b0);
    chk_b("midrst_eof", Eof, 1'b0);
    chk_b("midrst_busy", Busy, 1'b0);
    chk_b("midrst_done", Done, 1'b0);
    chk_b("midrst_ready", S_Ready, 1'b0);
    step();
    q.delete();
    fb = 0;
    rst = 1'b1;
    b0 = total_beats;
    repeat (4) step();
    chk_i("midrst_no_restart", total_beats - b0, 0);
    chk_b("midrst_idle", Busy, 1'b0);
    d0 = done_cnt;
    feed(0, 400, N);
    repeat (6) step();
    pulse_start();
    wait_done(d0, 200);
    check_data(400);

    // Random handshake with random data over several frames; surplus words carry over.
    d0 = done_cnt;
    b0 = total_beats;
    feed(2, 0, 5 * N);
    for (int f = 0; f < 4; f++) begin
      repeat ($urandom_range(5)) step();
      pulse_start();
      wait_done(d0 + f, 600);
    end
    feed_left = 0;
    repeat (4) step();
    chk_i("rand_beats", total_beats - b0, 4 * N);
    chk_i("rand_dones", done_cnt - d0, 4);
    chk_b("rand_idle", Busy, 1'b0);
    chk_b("rand_ready_vs_fill", S_Ready, q.size() < DEPTH);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
